// File: rtl/text_buffer.sv
// text_buffer: character-cell store for a text console.
// A text source writes bytes at a cursor. The pixel side reads the cell under
// (cx, cy) with a fixed two-cycle latency. The screen scrolls by rotating
// top_row instead of moving memory, and a clear FSM repaints blank cells.
module text_buffer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 30,
    parameter int         CELL_W    = 8,
    parameter int         CELL_H    = 16,
    parameter logic [7:0] FILL_ATTR = 8'h0F
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    output logic [7:0] codepoint,
    output logic [7:0] attribute,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_char,
    input  logic [7:0] wr_attr,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row
);

    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int CSH    = $clog2(CELL_W);
    localparam int RSH    = $clog2(CELL_H);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LINE_SPAN = ADDR_W'(COLS - 1);
    localparam logic [10:0]       X_LIM     = 11'(COLS * CELL_W);
    localparam logic [10:0]       Y_LIM     = 11'(ROWS * CELL_H);

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLEAR_LINE = 2'd1,
        CLEAR_ALL  = 2'd2
    } state_t;

    // Reduce a logical-row sum into 0..ROWS-1. The operands are each below
    // ROWS, so a single conditional subtract is enough.
    function automatic logic [10:0] wrap_row(input logic [10:0] s);
        logic [10:0] r;
        r = (s >= 11'(ROWS)) ? (s - 11'(ROWS)) : s;
        return r;
    endfunction

    state_t              state;
    logic [4:0]          top_row;
    logic [ADDR_W-1:0]   clr_addr;
    logic [ADDR_W-1:0]   clr_end;

    logic [15:0]         mem [CELLS];

    // Read pipeline signals
    logic [9:0]          col_p0;
    logic [9:0]          lrow_p0;
    logic                in_range_p0;
    logic [10:0]         phys_p0;
    logic [ADDR_W-1:0]   rd_addr_p0;
    logic [15:0]         rd_data_p1;
    logic                vld_p1;

    // Write-side decode
    logic                take;
    logic                is_lf_char;
    logic                is_cr_char;
    logic                is_ff_char;
    logic                is_print;
    logic                col_last;
    logic                row_last;
    logic                do_lf;
    logic [4:0]          top_next;
    logic [ADDR_W-1:0]   line_base;
    logic [10:0]         cur_phys;
    logic [ADDR_W-1:0]   cur_addr;

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [15:0]         wdata;

    // ---- stage p0: pixel position to cell address ----
    assign col_p0      = cx >> CSH;
    assign lrow_p0     = cy >> RSH;
    assign in_range_p0 = ({1'b0, cx} < X_LIM) && ({1'b0, cy} < Y_LIM);
    assign phys_p0     = wrap_row({1'b0, lrow_p0} + {6'd0, top_row});
    assign rd_addr_p0  = in_range_p0 ? ADDR_W'(int'(phys_p0) * COLS + int'(col_p0))
                                     : '0;

    // Byte classification and cursor address for the write side.
    assign take       = wr_valid && wr_ready && !reset;
    assign is_lf_char = (wr_char == CH_LF);
    assign is_cr_char = (wr_char == CH_CR);
    assign is_ff_char = (wr_char == CH_FF);
    assign is_print   = !(is_lf_char || is_cr_char || is_ff_char);
    assign col_last   = (cursor_col == 7'(COLS - 1));
    assign row_last   = (cursor_row == 5'(ROWS - 1));
    assign do_lf      = take && (is_lf_char || (is_print && col_last));
    assign top_next   = (top_row == 5'(ROWS - 1)) ? 5'd0 : (top_row + 5'd1);
    assign line_base  = ADDR_W'(int'(top_row) * COLS);
    assign cur_phys   = wrap_row({6'd0, cursor_row} + {6'd0, top_row});
    assign cur_addr   = ADDR_W'(int'(cur_phys) * COLS + int'(cursor_col));

    // Select the single write-port source: a printable byte in IDLE, or the blank fill in a clear state.
    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = {CH_SPACE, FILL_ATTR};
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (take && is_print) begin
                        we    = 1'b1;
                        waddr = cur_addr;
                        wdata = {wr_char, wr_attr};
                    end
                end
                CLEAR_LINE, CLEAR_ALL: we = 1'b1;
                default: we = 1'b0;
            endcase
        end
    end

    // Cell storage write port.
    always_ff @(posedge clk_pixel) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // ---- stage p1: registered memory read (read-first on collision) ----
    always_ff @(posedge clk_pixel) begin
        rd_data_p1 <= mem[rd_addr_p0];
        vld_p1     <= in_range_p0;
    end

    // ---- stage p2: output register, blanked off-screen ----
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            codepoint <= 8'h00;
            attribute <= 8'h00;
        end else if (vld_p1) begin
            codepoint <= rd_data_p1[15:8];
            attribute <= rd_data_p1[7:0];
        end else begin
            codepoint <= 8'h00;
            attribute <= 8'h00;
        end
    end

    // Control FSM: cursor movement, scrolling and clear sequencing.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state      <= CLEAR_ALL;
            wr_ready   <= 1'b0;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            top_row    <= 5'd0;
            clr_addr   <= '0;
            clr_end    <= LAST_CELL;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        if (is_ff_char) begin
                            cursor_col <= 7'd0;
                            cursor_row <= 5'd0;
                            top_row    <= 5'd0;
                            clr_addr   <= '0;
                            clr_end    <= LAST_CELL;
                            state      <= CLEAR_ALL;
                            wr_ready   <= 1'b0;
                        end else begin
                            if (is_print && !col_last) begin
                                cursor_col <= cursor_col + 7'd1;
                            end else begin
                                cursor_col <= 7'd0;
                            end
                            if (do_lf) begin
                                if (!row_last) begin
                                    cursor_row <= cursor_row + 5'd1;
                                end else begin
                                    // The old top physical row becomes the new bottom line.
                                    top_row  <= top_next;
                                    clr_addr <= line_base;
                                    clr_end  <= line_base + LINE_SPAN;
                                    state    <= CLEAR_LINE;
                                    wr_ready <= 1'b0;
                                end
                            end
                        end
                    end
                end
                CLEAR_LINE, CLEAR_ALL: begin
                    if (clr_addr == clr_end) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    state    <= CLEAR_ALL;
                    wr_ready <= 1'b0;
                    clr_addr <= '0;
                    clr_end  <= LAST_CELL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: pipelined read tables plus directed write sequences.
module tb_text_buffer;

    logic       clk_pixel;
    logic       reset;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [7:0] codepoint;
    logic [7:0] attribute;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_char;
    logic [7:0] wr_attr;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    int total = 0;
    int bad   = 0;

    text_buffer dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .cx         (cx),
        .cy         (cy),
        .codepoint  (codepoint),
        .attribute  (attribute),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_char    (wr_char),
        .wr_attr    (wr_attr),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        string      name;
        logic [9:0] cx;
        logic [9:0] cy;
        logic [7:0] cp;
        logic [7:0] at;
    } rd_vec_t;

    rd_vec_t tab[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_rd(input string nm, input int x, input int y,
                          input logic [7:0] cp, input logic [7:0] at);
        rd_vec_t v;
        v.name = nm;
        v.cx   = 10'(x);
        v.cy   = 10'(y);
        v.cp   = cp;
        v.at   = at;
        tab.push_back(v);
    endtask

    // A new position every cycle; each result is checked two cycles after it was driven.
    task automatic run_rd();
        int n;
        n = tab.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                check({tab[i-2].name, "_cp"}, 32'(codepoint), 32'(tab[i-2].cp));
                check({tab[i-2].name, "_at"}, 32'(attribute), 32'(tab[i-2].at));
            end
            if (i < n) begin
                cx = tab[i].cx;
                cy = tab[i].cy;
            end
            @(negedge clk_pixel);
        end
        tab.delete();
    endtask

    // Present a byte, hold it until wr_ready, return on the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] ch, input logic [7:0] at);
        int n;
        wr_valid = 1'b1;
        wr_char  = ch;
        wr_attr  = at;
        n = 0;
        while (!wr_ready && n < 5000) begin
            @(negedge clk_pixel);
            n++;
        end
        if (!wr_ready) check("send_timeout", 32'(wr_ready), 32'd1);
        @(negedge clk_pixel);
        wr_valid = 1'b0;
    endtask

    // Count negedges (starting with the current one) on which wr_ready is low.
    task automatic count_low(output int cnt);
        cnt = 0;
        while (!wr_ready && cnt < 5000) begin
            cnt++;
            @(negedge clk_pixel);
        end
    endtask

    initial begin
        int cnt;
        int drops;

        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_char  = 8'h00;
        wr_attr  = 8'h00;
        cx       = 10'd0;
        cy       = 10'd0;
        repeat (5) @(negedge clk_pixel);

        // Reset state
        check("rst_codepoint", 32'(codepoint), 32'h00);
        check("rst_attribute", 32'(attribute), 32'h00);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_cursor_col", 32'(cursor_col), 32'd0);
        check("rst_cursor_row", 32'(cursor_row), 32'd0);

        // Power-on clear
        reset = 1'b0;
        count_low(cnt);
        check("poweron_clear_cycles", 32'(cnt), 32'd2400);

        add_rd("blank_0_0",     0,   0,   8'h20, 8'h0F);
        add_rd("blank_mid",     321, 237, 8'h20, 8'h0F);
        add_rd("blank_corner",  639, 479, 8'h20, 8'h0F);
        add_rd("off_x640",      640, 0,   8'h00, 8'h00);
        add_rd("blank_after",   8,   16,  8'h20, 8'h0F);
        add_rd("off_y480",      0,   480, 8'h00, 8'h00);
        add_rd("off_max",       1023, 1023, 8'h00, 8'h00);
        run_rd();

        // Single printable byte at power-on cursor
        send_byte(8'h41, 8'h1E);
        check("A_cursor_col", 32'(cursor_col), 32'd1);
        check("A_cursor_row", 32'(cursor_row), 32'd0);
        add_rd("A_0_0",   0, 0,  8'h41, 8'h1E);
        add_rd("A_7_15",  7, 15, 8'h41, 8'h1E);
        add_rd("A_4_9",   4, 9,  8'h41, 8'h1E);
        add_rd("A_next",  8, 0,  8'h20, 8'h0F);
        add_rd("A_below", 0, 16, 8'h20, 8'h0F);
        run_rd();

        // Fill the rest of row 0 back-to-back; the column wrap moves to row 1
        drops = 0;
        for (int i = 1; i < 80; i++) begin
            if (!wr_ready) drops++;
            wr_valid = 1'b1;
            wr_char  = 8'(8'h40 + i);
            wr_attr  = 8'(i);
            @(negedge clk_pixel);
        end
        wr_valid = 1'b0;
        check("row_fill_ready_drops", 32'(drops), 32'd0);
        check("row_fill_cursor_col", 32'(cursor_col), 32'd0);
        check("row_fill_cursor_row", 32'(cursor_row), 32'd1);
        add_rd("fill_col1",  8,   0,  8'h41, 8'h01);
        add_rd("fill_col79", 632, 15, 8'h8F, 8'h4F);
        add_rd("fill_row1",  0,   16, 8'h20, 8'h0F);
        run_rd();

        // Carriage return then overwrite
        send_byte(8'h42, 8'h21);
        check("B_cursor_col", 32'(cursor_col), 32'd1);
        send_byte(8'h0D, 8'h00);
        check("cr_cursor_col", 32'(cursor_col), 32'd0);
        check("cr_cursor_row", 32'(cursor_row), 32'd1);
        send_byte(8'h43, 8'h5C);
        add_rd("cr_overwrite", 0, 16, 8'h43, 8'h5C);
        run_rd();

        // Line feeds down to the last row, no scrolling yet
        repeat (28) send_byte(8'h0A, 8'h00);
        check("lf_cursor_row", 32'(cursor_row), 32'd29);
        check("lf_cursor_col", 32'(cursor_col), 32'd0);
        check("lf_no_scroll_ready", 32'(wr_ready), 32'd1);
        send_byte(8'h5A, 8'h2A);

        // Scroll: old top row becomes a freshly cleared bottom row
        send_byte(8'h0A, 8'h00);
        count_low(cnt);
        check("scroll_clear_cycles", 32'(cnt), 32'd80);
        check("scroll_cursor_row", 32'(cursor_row), 32'd29);
        check("scroll_cursor_col", 32'(cursor_col), 32'd0);
        add_rd("scr_top_C",     0,   0,   8'h43, 8'h5C);
        add_rd("scr_top_col1",  8,   0,   8'h20, 8'h0F);
        add_rd("scr_row28_Z",   0,   448, 8'h5A, 8'h2A);
        add_rd("scr_bot_col0",  0,   464, 8'h20, 8'h0F);
        add_rd("scr_bot_col1",  8,   464, 8'h20, 8'h0F);
        add_rd("scr_bot_col79", 632, 479, 8'h20, 8'h0F);
        add_rd("scr_off_x",     640, 0,   8'h00, 8'h00);
        run_rd();

        // Writes on the bottom row land in the recycled physical row
        send_byte(8'h51, 8'h33);
        add_rd("bot_Q_0",  0, 464, 8'h51, 8'h33);
        add_rd("bot_Q_7",  7, 479, 8'h51, 8'h33);
        add_rd("bot_topC", 0, 0,   8'h43, 8'h5C);
        run_rd();

        // Form feed with the next byte held valid throughout the clear
        send_byte(8'h0C, 8'h00);
        check("ff_cursor_col", 32'(cursor_col), 32'd0);
        check("ff_cursor_row", 32'(cursor_row), 32'd0);
        wr_valid = 1'b1;
        wr_char  = 8'h58;
        wr_attr  = 8'h44;
        count_low(cnt);
        check("ff_clear_cycles", 32'(cnt), 32'd2400);
        @(negedge clk_pixel);
        wr_valid = 1'b0;
        check("ff_next_cursor_col", 32'(cursor_col), 32'd1);
        check("ff_next_cursor_row", 32'(cursor_row), 32'd0);
        add_rd("ff_X",       0, 0,   8'h58, 8'h44);
        add_rd("ff_row1",    0, 16,  8'h20, 8'h0F);
        add_rd("ff_row28",   0, 448, 8'h20, 8'h0F);
        add_rd("ff_row29",   0, 464, 8'h20, 8'h0F);
        run_rd();

        // Reset in the middle of a full clear restarts it from cell 0
        send_byte(8'h0C, 8'h00);
        cx = 10'd0;
        cy = 10'd0;
        repeat (1000) @(negedge clk_pixel);
        reset = 1'b1;
        repeat (3) @(negedge clk_pixel);
        check("midrst_wr_ready", 32'(wr_ready), 32'd0);
        check("midrst_codepoint", 32'(codepoint), 32'h00);
        check("midrst_attribute", 32'(attribute), 32'h00);
        check("midrst_cursor_col", 32'(cursor_col), 32'd0);
        reset = 1'b0;
        count_low(cnt);
        check("midrst_clear_cycles", 32'(cnt), 32'd2400);
        add_rd("midrst_cell0", 0,   0,   8'h20, 8'h0F);
        add_rd("midrst_last",  639, 479, 8'h20, 8'h0F);
        run_rd();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
